fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-cycle core. Holds the program counter, issues one request per instruction to instruction memory, latches the returned word and presents it, with its opcode field, to the decoder. It computes the next PC from the outcome of the retiring instruction: sequential, branch taken, or jump.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset. Must be 4-byte aligned.
- `NOP_INSTR`, default 32'h0000_0013: instruction register value after reset (`addi x0,x0,0`).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `imem_req_o`  out  1  one-cycle request pulse to instruction memory.
- `imem_addr_o`  out  32  fetch address; valid while `imem_req_o`=1, otherwise equal to `pc_o`.
- `imem_rvalid_i`  in  1  response strobe; exactly one per request, 1 or more cycles after the request.
- `imem_rdata_i`  in  32  instruction word; valid with `imem_rvalid_i`.
- `stall_i`  in  1  back end busy; blocks retirement.
- `retire_i`  in  1  back end finished the presented instruction.
- `branch_i`  in  1  branch control for the presented instruction.
- `zero_i`  in  1  ALU zero / condition result for the presented instruction.
- `tipoJ_i`  in  1  jump control for the presented instruction.
- `target_i`  in  32  branch/jump target for the presented instruction.
- `instr_o`  out  32  latched instruction.
- `opcode_o`  out  7  `instr_o[6:0]`; feeds the decoder opcode input.
- `pc_o`  out  32  address of `instr_o`.
- `pc_plus4_o`  out  32  `pc_o + 4`, modulo 2^32.
- `instr_valid_o`  out  1  `instr_o` is valid and awaiting retirement.
- `misalign_o`  out  1  sticky flag; set when a taken redirect has `target_i[1:0]` ≠ 0.
- `instret_o`  out  32  retired-instruction counter; wraps.

## Operation
- FSM states: REQ, WAIT, HOLD. Reset enters REQ.
- **REQ:** `imem_req_o`=1, `imem_addr_o`=`pc_o`. Go to WAIT next cycle unconditionally.
- **WAIT:** `imem_rvalid_i` is sampled only in this state.
  - On `imem_rvalid_i`=1: `instr_o` ← `imem_rdata_i`, then go to HOLD.
  - Otherwise: stay in WAIT. There is no timeout.
- **HOLD:** `instr_valid_o`=1.
  - Retirement occurs when `retire_i`=1 and `stall_i`=0.
  - Taken = `tipoJ_i` | (`branch_i` & `zero_i`).
  - On retirement, PC ← taken ? {`target_i`[31:2],2'b00} : `pc_o`+4.
  - On retirement, `instret_o` += 1 and the FSM goes to REQ.
  - Without retirement, all state holds.
- `misalign_o` is set on a taken retirement with `target_i[1:0]` ≠ 0. It clears only on reset.
- `imem_rvalid_i` in REQ or HOLD is ignored. `retire_i` outside HOLD is ignored.
- Control inputs (`branch_i`, `zero_i`, `tipoJ_i`, `target_i`) are sampled only in the retiring cycle.
- Arithmetic: PC and counter are 32-bit unsigned, with wrap-around (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset values:
  - `pc_o`=`RESET_PC`, `imem_addr_o`=`RESET_PC`, `pc_plus4_o`=`RESET_PC`+4
  - `instr_o`=`NOP_INSTR`, `opcode_o`=7'b0010011
  - `instr_valid_o`=0, `imem_req_o`=0, `misalign_o`=0, `instret_o`=0
  - state = REQ
- First request: `imem_req_o`=1 in the first clock cycle after `rst_ni` deasserts.
- Memory latency L ≥ 1: request in cycle t, `imem_rvalid_i` in cycle t+L, `instr_valid_o`=1 from cycle t+L+1.
- Minimum throughput: 3 cycles per instruction (REQ, WAIT with L=1, HOLD with same-cycle retire).
- Retire in cycle h: new PC and `instret_o` are visible in h+1, together with `imem_req_o`=1. `instr_valid_o` falls in h+1.
- `instr_o`, `pc_o` and `opcode_o` are stable for the whole of HOLD.
- Reset asserted in any state clears all state immediately. Any outstanding request is abandoned; instruction memory shares `rst_ni`, so no stale response arrives.

## Test plan
- Reset release with L=1, immediate retire, no branches:
  - `imem_addr_o` sequence is 0x0, 0x4, 0x8.
  - Each request is 3 cycles apart.
  - `instret_o`=3 after the third retire.
- L=4 with `imem_rdata_i`=32'h00A00093:
  - `instr_valid_o` rises 5 cycles after the request.
  - `opcode_o`=7'b0010011.
  - `imem_rvalid_i` pulsed during HOLD is ignored.
- Branch retire at `pc_o`=0x10, `branch_i`=1, `target_i`=0x40:
  - With `zero_i`=1: next `imem_addr_o`=0x40.
  - With `zero_i`=0: next `imem_addr_o`=0x14.
- Jump retire with `tipoJ_i`=1, `target_i`=0x102:
  - Next PC is 0x100.
  - `misalign_o`=1 and stays set through subsequent fetches.
- `stall_i`=1 for 5 cycles with `retire_i`=1 in HOLD:
  - No PC or counter change and no request during the stall.
  - Retire occurs in the cycle after `stall_i` falls.
- Wrap and reset:
  - `RESET_PC`=0xFFFF_FFFC: after one retire, `imem_addr_o`=0x0.
  - Assert `rst_ni`=0 during WAIT: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the single-cycle core.
// - Holds the program counter.
// - Issues one request per instruction to instruction memory.
// - Latches the returned word and presents it, with its opcode field, to the
//   decoder.
// - When the back end retires the presented instruction, picks the next PC:
//   sequential, branch taken, or jump.
//
// Parameters:
//   RESET_PC   PC after reset (4-byte aligned)
//   NOP_INSTR  instruction register contents after reset
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   imem_req_o     one-cycle request pulse to instruction memory
//   imem_addr_o    fetch address (always equal to pc_o)
//   imem_rvalid_i  response strobe, one per request
//   imem_rdata_i   instruction word, valid with imem_rvalid_i
//   stall_i        back end busy, blocks retirement
//   retire_i       back end finished the presented instruction
//   branch_i       branch control of the presented instruction
//   zero_i         ALU zero / condition result of the presented instruction
//   tipoJ_i        jump control of the presented instruction
//   target_i       branch/jump target of the presented instruction
//   instr_o        latched instruction
//   opcode_o       instr_o[6:0]
//   pc_o           address of instr_o
//   pc_plus4_o     pc_o + 4 (wraps)
//   instr_valid_o  instr_o valid and awaiting retirement
//   misalign_o     sticky: a taken redirect had a misaligned target
//   instret_o      retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        retire_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        tipoJ_i,
    input  logic [31:0] target_i,
    output logic [31:0] instr_o,
    output logic [6:0]  opcode_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    output logic        misalign_o,
    output logic [31:0] instret_o
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] instret_reg;
    logic        valid_reg;
    logic        misalign_reg;

    logic        retire_ok;
    logic        taken;
    logic        target_misaligned;
    logic [31:0] pc_seq;
    logic [31:0] pc_next;

    // Retirement only counts while an instruction is actually presented.
    assign retire_ok         = (state_reg == ST_HOLD) && retire_i && !stall_i;
    assign taken             = tipoJ_i | (branch_i & zero_i);
    assign target_misaligned = |target_i[1:0];
    assign pc_seq            = pc_reg + 32'd4;
    // Redirect targets are forced to word alignment; the low bits only feed
    // the sticky misalign flag.
    assign pc_next           = taken ? {target_i[31:2], 2'b00} : pc_seq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_REQ;
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            instret_reg  <= 32'd0;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_REQ: begin
                    // The request is issued for exactly this one cycle.
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        instr_reg <= imem_rdata_i;
                        valid_reg <= 1'b1;
                        state_reg <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (retire_ok) begin
                        pc_reg      <= pc_next;
                        instret_reg <= instret_reg + 32'd1;
                        valid_reg   <= 1'b0;
                        state_reg   <= ST_REQ;
                        if (taken && target_misaligned) begin
                            misalign_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_REQ;
                end
            endcase
        end
    end

    // Reset parks the FSM in REQ, but no request may go out while reset is
    // held. Gating with rst_ni lets the first request appear in the very
    // first cycle after reset is released.
    assign imem_req_o    = (state_reg == ST_REQ) && rst_ni;
    assign imem_addr_o   = pc_reg;
    assign pc_o          = pc_reg;
    assign pc_plus4_o    = pc_seq;
    assign instr_o       = instr_reg;
    assign opcode_o      = instr_reg[6:0];
    assign instr_valid_o = valid_reg;
    assign misalign_o    = misalign_reg;
    assign instret_o     = instret_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;

    // Main instance (default parameters).
    logic        req, rvalid, stall, retire, branch, zero, tipo_j, valid, misalign;
    logic [31:0] addr, rdata, target, instr, pc, pc4, instret;
    logic [6:0]  opcode;

    // Second instance with a reset PC at the top of the address space.
    logic        w_req, w_rvalid, w_retire, w_valid, w_misalign;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4, w_instret;
    logic [6:0]  w_opcode;

    fetch_unit u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .stall_i(stall), .retire_i(retire), .branch_i(branch), .zero_i(zero),
        .tipoJ_i(tipo_j), .target_i(target),
        .instr_o(instr), .opcode_o(opcode), .pc_o(pc), .pc_plus4_o(pc4),
        .instr_valid_o(valid), .misalign_o(misalign), .instret_o(instret)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
        .stall_i(1'b0), .retire_i(w_retire), .branch_i(1'b0), .zero_i(1'b0),
        .tipoJ_i(1'b0), .target_i(32'h0),
        .instr_o(w_instr), .opcode_o(w_opcode), .pc_o(w_pc), .pc_plus4_o(w_pc4),
        .instr_valid_o(w_valid), .misalign_o(w_misalign), .instret_o(w_instret)
    );

    int          total = 0;
    int          bad = 0;
    int unsigned exp_instret = 0;
    int unsigned req_cyc = 0;
    int unsigned prev_req_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge inside a REQ cycle. Serves the request with latency
    // lat and returns at the negedge of the first HOLD cycle.
    task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] data, input int lat);
        check("req_high", {31'd0, req}, 32'd1);
        check("req_addr", addr, exp_pc);
        prev_req_cyc = req_cyc;
        req_cyc = cyc;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("wait_req_low", {31'd0, req}, 32'd0);
            check("wait_not_valid", {31'd0, valid}, 32'd0);
            if (k == lat) begin
                rvalid = 1'b1;
                rdata  = data;
            end
        end
        @(negedge clk);
        rvalid = 1'b0;
        check("hold_valid", {31'd0, valid}, 32'd1);
        check("hold_instr", instr, data);
        check("valid_latency", cyc - req_cyc, lat + 1);
        $display("fetch  pc=%h instr=%h lat=%0d", pc, instr, lat);
    endtask

    // Entered at a HOLD negedge; retires there and returns at the negedge of
    // the following REQ cycle with the expected next PC checked.
    task automatic retire_with(input logic br, input logic z, input logic j,
                               input logic [31:0] tgt, input logic [31:0] exp_next);
        retire = 1'b1; branch = br; zero = z; tipo_j = j; target = tgt;
        @(negedge clk);
        retire = 1'b0; branch = 1'b0; zero = 1'b0; tipo_j = 1'b0; target = 32'h0;
        exp_instret++;
        check("retire_valid_fall", {31'd0, valid}, 32'd0);
        check("retire_next_pc", addr, exp_next);
        check("retire_instret", instret, exp_instret);
        $display("retire next_pc=%h instret=%0d", addr, instret);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rvalid = 1'b0; rdata = 32'h0; stall = 1'b0; retire = 1'b0;
        branch = 1'b0; zero = 1'b0; tipo_j = 1'b0; target = 32'h0;
        w_rvalid = 1'b0; w_rdata = 32'h0; w_retire = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_pc4", pc4, 32'h4);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_opcode", {25'd0, opcode}, 32'h13);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_rst_pc4", w_pc4, 32'h0);

        // Release; request must appear in the same cycle.
        rst_n = 1'b1;
        #1;
        check("first_req", {31'd0, req}, 32'd1);
        @(negedge clk);
        // Still in the first cycle after release (release was at a negedge).
        // Step back: the negedge above ended that cycle, so re-align by
        // resetting once more and releasing exactly at a negedge.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;

        // Sequential fetches, L=1, immediate retire.
        fetch(32'h0, 32'h0010_0093, 1);
        retire_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        fetch(32'h4, 32'h0020_0113, 1);
        check("req_spacing_1", req_cyc - prev_req_cyc, 32'd3);
        retire_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h8);
        fetch(32'h8, 32'h0030_0193, 1);
        check("req_spacing_2", req_cyc - prev_req_cyc, 32'd3);
        retire_with(1'b0, 1'b0, 1'b0, 32'h0, 32'hC);
        check("instret_three", instret, 32'd3);

        // L=4, then a stray response during HOLD.
        fetch(32'hC, 32'h00A0_0093, 4);
        check("opcode_addi", {25'd0, opcode}, 32'h13);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rvalid = 1'b0;
        check("stray_rvalid_instr", instr, 32'h00A0_0093);
        check("stray_rvalid_valid", {31'd0, valid}, 32'd1);
        retire_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h10);

        // Branch at 0x10, taken.
        fetch(32'h10, 32'h0000_0063, 1);
        retire_with(1'b1, 1'b1, 1'b0, 32'h40, 32'h40);
        // Jump back to 0x10, then branch not taken.
        fetch(32'h40, 32'h0000_006F, 1);
        retire_with(1'b0, 1'b0, 1'b1, 32'h10, 32'h10);
        fetch(32'h10, 32'h0000_0063, 1);
        retire_with(1'b1, 1'b0, 1'b0, 32'h40, 32'h14);
        check("no_misalign_yet", {31'd0, misalign}, 32'd0);

        // Misaligned jump target.
        fetch(32'h14, 32'h0000_006F, 1);
        retire_with(1'b0, 1'b0, 1'b1, 32'h102, 32'h100);
        check("misalign_set", {31'd0, misalign}, 32'd1);
        fetch(32'h100, 32'h0040_0213, 2);
        retire_with(1'b0, 1'b0, 1'b0, 32'h0, 32'h104);
        check("misalign_sticky", {31'd0, misalign}, 32'd1);

        // Stall for 5 cycles with retire held high.
        fetch(32'h104, 32'h0050_0293, 1);
        stall = 1'b1; retire = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'h104);
            check("stall_instret", instret, exp_instret);
            check("stall_req", {31'd0, req}, 32'd0);
            check("stall_valid", {31'd0, valid}, 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        retire = 1'b0;
        exp_instret++;
        check("post_stall_req", {31'd0, req}, 32'd1);
        check("post_stall_pc", addr, 32'h108);
        check("post_stall_instret", instret, exp_instret);
        $display("retire next_pc=%h instret=%0d (after stall)", addr, instret);

        // Asynchronous reset while in WAIT.
        check("pre_rst_req", {31'd0, req}, 32'd1);
        @(negedge clk);
        check("in_wait", {31'd0, req}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_pc4", pc4, 32'h4);
        check("arst_instr", instr, 32'h0000_0013);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_req", {31'd0, req}, 32'd0);
        check("arst_misalign", {31'd0, misalign}, 32'd0);
        check("arst_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerelease_req", {31'd0, req}, 32'd1);
        check("rerelease_addr", addr, 32'h0);

        // Wrap-around on the high-reset-PC instance (in REQ with u_dut).
        check("wrap_req", {31'd0, w_req}, 32'd1);
        check("wrap_addr", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        w_rvalid = 1'b1; w_rdata = 32'h0060_0313;
        @(negedge clk);
        w_rvalid = 1'b0;
        check("wrap_valid", {31'd0, w_valid}, 32'd1);
        check("wrap_instr", w_instr, 32'h0060_0313);
        w_retire = 1'b1;
        @(negedge clk);
        w_retire = 1'b0;
        check("wrap_next_addr", w_addr, 32'h0);
        check("wrap_next_req", {31'd0, w_req}, 32'd1);
        check("wrap_instret", w_instret, 32'd1);
        $display("retire wrap next_pc=%h instret=%0d", w_addr, w_instret);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
